mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (PC stage) and data access (MEM stage).

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_timer.sv | 31 +++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant owners
// and the width of the WAIT timeout counter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam int TIMER_W = 8;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Timeout counter for the WAIT state: cleared outside WAIT, counts each
// waiting cycle and flags the cycle on which the limit is reached.
module mem_arb_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

   logic [TIMER_W-1:0] count_q;

   // Count cycles spent waiting on the memory, restarting from zero per access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count_q <= '0;
      else if (clear)
         count_q <= '0;
      else if (enable)
         count_q <= count_q + TIMER_W'(1);
   end

   assign terminal = enable && (count_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// One access at a time, bounded by a timeout, with a streak limit that keeps
// a busy data side from starving fetch. All outputs are registered.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 255,
   parameter int MAX_DSTREAK = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          owner
);

   localparam int            SW         = $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

   arb_state_t    state_q, state_d;
   owner_t        owner_q, owner_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          grant, grant_data;
   logic          timer_term, access_end;

   logic          mem_req_d, mem_we_d;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_wdata_d;
   logic          if_ack_d, d_ack_d, err_d;
   logic [DW-1:0] if_rdata_d, d_rdata_d;

   mem_arb_timer #(
      .LIMIT    (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (state_q != ST_WAIT),
      .enable   (state_q == ST_WAIT),
      .terminal (timer_term)
   );

   assign access_end = (state_q == ST_WAIT) && (mem_ack || timer_term);
   assign owner      = owner_q;

   // Pick the winner in IDLE: data first unless fetch has waited out a full streak
   always_comb begin
      grant      = 1'b0;
      grant_data = 1'b0;
      streak_d   = streak_q;
      if (state_q == ST_IDLE) begin
         if (d_req && !(if_req && (streak_q == STREAK_MAX))) begin
            grant      = 1'b1;
            grant_data = 1'b1;
         end else if (if_req) begin
            grant = 1'b1;
         end
      end
      if (grant) begin
         if (grant_data && if_req)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
         else
            streak_d = '0;
      end
   end

   // Hold the FSM state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Step through one access: IDLE grants, WAIT ends on ack or timeout, DONE lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant) state_d = ST_WAIT;
         ST_WAIT: if (access_end) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Work out the next registered outputs; a stray mem_ack outside WAIT changes nothing
   always_comb begin
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      owner_d     = owner_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      err_d       = 1'b0;
      if_rdata_d  = '0;
      d_rdata_d   = '0;
      if (grant) begin
         mem_req_d   = 1'b1;
         owner_d     = grant_data ? OWN_D : OWN_IF;
         mem_we_d    = grant_data ? d_we : 1'b0;
         mem_addr_d  = grant_data ? d_addr : if_addr;
         mem_wdata_d = grant_data ? d_wdata : '0;
      end else if (access_end) begin
         mem_req_d   = 1'b0;
         mem_we_d    = 1'b0;
         mem_addr_d  = '0;
         mem_wdata_d = '0;
         err_d       = !mem_ack;
         if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
         end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
         end
      end
   end

   // Register outputs, owner and streak so reset drops everything at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         err       <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         owner_q   <= OWN_IF;
         streak_q  <= '0;
      end else begin
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         if_ack    <= if_ack_d;
         d_ack     <= d_ack_d;
         err       <= err_d;
         if_rdata  <= if_rdata_d;
         d_rdata   <= d_rdata_d;
         owner_q   <= owner_d;
         streak_q  <= streak_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A transaction-level model predicts every
// registered output from the request inputs and the planned memory latency:
// each access finishes min(lat+1, TIMEOUT) edges after its grant and the
// arbiter samples again two edges later. Inputs change on the falling edge,
// outputs are compared on the falling edge.
module tb_mem_port_arbiter;

   localparam int AW          = 32;
   localparam int DW          = 32;
   localparam int TIMEOUT     = 8;
   localparam int MAX_DSTREAK = 4;
   localparam int NEVER       = 1000;

   logic          clk, rst;
   logic          if_req, if_ack, d_req, d_we, d_ack, err;
   logic [AW-1:0] if_addr, d_addr, mem_addr;
   logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
   logic          mem_req, mem_we, mem_ack, owner;

   int tests = 0;
   int fails = 0;

   // Model state and predicted outputs
   int          cyc = 0, done_edge = -10, ack_edge = -10, m_lat = 0, streak = 0;
   int          plan_lat = 0;
   logic [31:0] plan_data = 0, acc_data = 0;
   bit          busy = 0, acc_ok = 0, acc_is_d = 0, rand_plan = 0;
   bit          stray_en = 0, manual_ack = 0, sched = 0, stray = 0;
   logic        e_mem_req = 0, e_mem_we = 0, e_owner = 0, e_if_ack = 0, e_d_ack = 0, e_err = 0;
   logic [31:0] e_mem_addr = 0, e_mem_wdata = 0, e_if_rdata = 0, e_d_rdata = 0;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_DSTREAK(MAX_DSTREAK)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [133:0] dut_vec();
      return {mem_req, mem_we, mem_addr, mem_wdata, owner, if_ack, d_ack, err, if_rdata, d_rdata};
   endfunction

   function automatic logic [133:0] model_vec();
      return {e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata, e_owner, e_if_ack, e_d_ack, e_err,
              e_if_rdata, e_d_rdata};
   endfunction

   // Transaction model: grant rule, streak rule and completion time by arithmetic
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy = 0; streak = 0; done_edge = -10; ack_edge = -10;
         e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_owner = 0;
         e_if_ack = 0; e_d_ack = 0; e_err = 0; e_if_rdata = 0; e_d_rdata = 0;
      end else begin
         cyc++;
         e_if_ack = 0; e_d_ack = 0; e_err = 0; e_if_rdata = 0; e_d_rdata = 0;
         if (busy) begin
            if (cyc == done_edge) begin
               e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
               e_err = !acc_ok;
               if (acc_is_d) begin
                  e_d_ack = 1; e_d_rdata = acc_ok ? acc_data : 32'h0;
               end else begin
                  e_if_ack = 1; e_if_rdata = acc_ok ? acc_data : 32'h0;
               end
            end else if (cyc == done_edge + 1) begin
               busy = 0;
            end
         end else if (if_req || d_req) begin
            acc_is_d = d_req && !(if_req && streak == MAX_DSTREAK);
            if (acc_is_d && if_req) begin
               if (streak < MAX_DSTREAK) streak++;
            end else begin
               streak = 0;
            end
            m_lat     = rand_plan ? int'($urandom_range(0, 10)) : plan_lat;
            acc_data  = rand_plan ? $urandom : plan_data;
            acc_ok    = (m_lat + 1 <= TIMEOUT);
            done_edge = cyc + (acc_ok ? m_lat + 1 : TIMEOUT);
            ack_edge  = cyc + m_lat + 1;
            busy      = 1;
            e_mem_req   = 1;
            e_owner     = acc_is_d;
            e_mem_we    = acc_is_d ? d_we : 1'b0;
            e_mem_addr  = acc_is_d ? d_addr : if_addr;
            e_mem_wdata = acc_is_d ? d_wdata : 32'h0;
         end
      end
   end

   // Memory responder: ack on the planned edge, optional stray acks outside WAIT
   always @(negedge clk) begin
      sched     = busy && (cyc + 1 == ack_edge) && (ack_edge <= done_edge);
      stray     = stray_en && (!busy || cyc >= done_edge) && ($urandom_range(0, 3) == 0);
      mem_ack   = sched || stray || manual_ack;
      mem_rdata = sched ? acc_data : $urandom;
   end

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got %h want 0", dut_vec());
         end
      end
      tests++;
      if (dut_vec() !== model_vec()) begin
         fails++;
         $display("[TB] FAIL reset_model got %h want %h", dut_vec(), model_vec());
      end
      rst = 1;
   endtask

   task automatic test_fetch_only();
      int req_cycles = 0;
      int acks = 0;
      plan_lat = 2; plan_data = 32'hDEADBEEF;
      @(negedge clk);
      if_addr = 32'h100; if_req = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== model_vec()) begin
            fails++;
            $display("[TB] FAIL fetch_model got %h want %h", dut_vec(), model_vec());
         end
         if (mem_req) begin
            req_cycles++;
            tests++;
            if ({mem_we, mem_addr} !== {1'b0, 32'h100}) begin
               fails++;
               $display("[TB] FAIL fetch_mem_addr got we=%b addr=%h want we=0 addr=100", mem_we, mem_addr);
            end
         end
         if (if_ack) begin
            acks++;
            tests++;
            if ({err, if_rdata} !== {1'b0, 32'hDEADBEEF}) begin
               fails++;
               $display("[TB] FAIL fetch_rdata got err=%b data=%h want err=0 data=deadbeef", err, if_rdata);
            end
         end
         if (e_if_ack) if_req = 0;
      end
      tests++;
      if (req_cycles !== 3) begin
         fails++;
         $display("[TB] FAIL fetch_req_len got %0d want 3", req_cycles);
      end
      tests++;
      if (acks !== 1) begin
         fails++;
         $display("[TB] FAIL fetch_ack_count got %0d want 1", acks);
      end
   endtask

   task automatic test_both_first();
      int first_owner = -1;
      int d_at = -1;
      int if_at = -1;
      plan_lat = 0; plan_data = $urandom;
      @(negedge clk);
      if_addr = $urandom; d_addr = $urandom; d_we = 0; d_wdata = $urandom;
      if_req = 1; d_req = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== model_vec()) begin
            fails++;
            $display("[TB] FAIL both_model got %h want %h", dut_vec(), model_vec());
         end
         if (mem_req && first_owner < 0) first_owner = int'(owner);
         if (d_ack && d_at < 0) d_at = i;
         if (if_ack && if_at < 0) if_at = i;
         if (e_d_ack) d_req = 0;
         if (e_if_ack) if_req = 0;
      end
      tests++;
      if (first_owner !== 1) begin
         fails++;
         $display("[TB] FAIL both_first_owner got %0d want 1", first_owner);
      end
      tests++;
      if (d_at < 0 || if_at < 0 || d_at >= if_at) begin
         fails++;
         $display("[TB] FAIL both_ack_order got d_at=%0d if_at=%0d want d_ack before if_ack", d_at, if_at);
      end
   endtask

   task automatic test_streak();
      int   n = 0;
      logic prev_req = 0;
      logic exp_owner;
      plan_lat = 0; plan_data = $urandom;
      @(negedge clk);
      if_addr = $urandom; d_addr = $urandom; d_we = 0; d_wdata = $urandom;
      if_req = 1; d_req = 1;
      for (int i = 0; i < 200 && n < 10; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== model_vec()) begin
            fails++;
            $display("[TB] FAIL streak_model got %h want %h", dut_vec(), model_vec());
         end
         if (mem_req && !prev_req) begin
            exp_owner = ((n % (MAX_DSTREAK + 1)) < MAX_DSTREAK);
            tests++;
            if (owner !== exp_owner) begin
               fails++;
               $display("[TB] FAIL streak_grant_%0d got owner=%b want %b", n, owner, exp_owner);
            end
            n++;
         end
         prev_req = mem_req;
         if (e_d_ack) d_req = 0;
         else if (!d_req) begin d_req = 1; d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom; end
         if (e_if_ack) if_req = 0;
         else if (!if_req) begin if_req = 1; if_addr = $urandom; end
      end
      tests++;
      if (n !== 10) begin
         fails++;
         $display("[TB] FAIL streak_grant_count got %0d want 10", n);
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== model_vec()) begin
            fails++;
            $display("[TB] FAIL streak_drain got %h want %h", dut_vec(), model_vec());
         end
         if (e_d_ack) d_req = 0;
         if (e_if_ack) if_req = 0;
      end
   endtask

   task automatic test_timeout();
      int          lats[3]    = '{NEVER, TIMEOUT - 1, 1};
      int          exp_len[3] = '{TIMEOUT, TIMEOUT, 2};
      int          req_cycles;
      int          acks;
      logic [31:0] exp_data;
      for (int a = 0; a < 3; a++) begin
         plan_lat = lats[a]; plan_data = $urandom;
         req_cycles = 0; acks = 0;
         @(negedge clk);
         d_req = 1; d_we = 0; d_addr = $urandom; d_wdata = $urandom;
         for (int i = 0; i < TIMEOUT + 8; i++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== model_vec()) begin
               fails++;
               $display("[TB] FAIL timeout_model_%0d got %h want %h", a, dut_vec(), model_vec());
            end
            if (mem_req) req_cycles++;
            if (d_ack) begin
               acks++;
               exp_data = (a == 0) ? 32'h0 : plan_data;
               tests++;
               if ({err, d_rdata} !== {(a == 0), exp_data}) begin
                  fails++;
                  $display("[TB] FAIL timeout_result_%0d got err=%b data=%h want err=%b data=%h",
                           a, err, d_rdata, (a == 0), exp_data);
               end
            end
            if (e_d_ack) d_req = 0;
         end
         tests++;
         if (req_cycles !== exp_len[a]) begin
            fails++;
            $display("[TB] FAIL timeout_req_len_%0d got %0d want %0d", a, req_cycles, exp_len[a]);
         end
         tests++;
         if (acks !== 1) begin
            fails++;
            $display("[TB] FAIL timeout_ack_count_%0d got %0d want 1", a, acks);
         end
      end
   endtask

   task automatic test_store();
      int we_cycles = 0;
      int ack_at = -1;
      plan_lat = 0; plan_data = $urandom;
      @(negedge clk);
      d_we = 1; d_addr = 32'h40; d_wdata = 32'h1234; d_req = 1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== model_vec()) begin
            fails++;
            $display("[TB] FAIL store_model got %h want %h", dut_vec(), model_vec());
         end
         if (mem_req) begin
            tests++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h40, 32'h1234}) begin
               fails++;
               $display("[TB] FAIL store_mem got we=%b addr=%h wdata=%h want 1/40/1234", mem_we, mem_addr, mem_wdata);
            end
         end
         if (mem_we) we_cycles++;
         if (d_ack) begin
            if (ack_at < 0) ack_at = i;
            tests++;
            if ({err, d_rdata} !== {1'b0, plan_data}) begin
               fails++;
               $display("[TB] FAIL store_ack got err=%b data=%h want err=0 data=%h", err, d_rdata, plan_data);
            end
         end
         if (e_d_ack) d_req = 0;
      end
      tests++;
      if (we_cycles !== 1) begin
         fails++;
         $display("[TB] FAIL store_we_len got %0d want 1", we_cycles);
      end
      // request cycle, WAIT cycle, then the ack cycle
      tests++;
      if (ack_at !== 2) begin
         fails++;
         $display("[TB] FAIL store_latency got %0d want 2", ack_at);
      end
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      plan_lat = NEVER;
      @(negedge clk);
      if_req = 1; if_addr = $urandom;
      for (int w = 0; w < 10 && !mem_req; w++) @(negedge clk);
      tests++;
      if (mem_req !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_mid_grant got mem_req=%b want 1", mem_req);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      tests++;
      if (dut_vec() !== '0) begin
         fails++;
         $display("[TB] FAIL reset_mid_async got %h want 0", dut_vec());
      end
      if_req = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         manual_ack = (i < 4);
         tests++;
         if (dut_vec() !== model_vec() || mem_req || if_ack || d_ack) begin
            fails++;
            $display("[TB] FAIL reset_mid_stray got %h want %h", dut_vec(), model_vec());
         end
      end
      manual_ack = 0;
      plan_lat = 0; plan_data = $urandom;
      @(negedge clk);
      if_req = 1; if_addr = $urandom;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== model_vec()) begin
            fails++;
            $display("[TB] FAIL reset_mid_after got %h want %h", dut_vec(), model_vec());
         end
         if (if_ack) acks++;
         if (e_if_ack) if_req = 0;
      end
      tests++;
      if (acks !== 1) begin
         fails++;
         $display("[TB] FAIL reset_mid_after_ack got %0d want 1", acks);
      end
   endtask

   task automatic test_random();
      rand_plan = 1; stray_en = 1;
      for (int i = 0; i < 440; i++) begin
         @(negedge clk);
         tests++;
         if (dut_vec() !== model_vec()) begin
            fails++;
            $display("[TB] FAIL random_model cycle %0d got %h want %h", i, dut_vec(), model_vec());
         end
         if (e_if_ack) if_req = 0;
         else if (!if_req && i < 400 && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom;
         end
         if (e_d_ack) d_req = 0;
         else if (!d_req && i < 400 && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom;
         end
      end
      rand_plan = 0; stray_en = 0;
   endtask

   initial begin
      rst = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      test_reset();
      test_fetch_only();
      test_both_first();
      test_streak();
      test_timeout();
      test_store();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
